uart_rx_wb: RTL

//  Serial receive end of the j1_top UART link: deserialises 8-bit frames arriving on rx,

---
 rtl/uart_rx_wb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_wb.sv
// UART 8-bit receiver with 16x oversampling, small receive FIFO and a Wishbone classic slave.
// Define UART_RX_PARITY_EN to accept 8E1 frames (even parity checked, PERR flag); default is 8N1.
module uart_rx_wb #(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        rx,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        rx_avail
);
  localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_MAX = TW'(OVS_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    smp_q, smp_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shr_q, shr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic          ferr_q, ferr_d, ovr_q, ovr_d, perr_q, perr_d;
  logic          ack_q, ack_d, avail_q, avail_d;
  logic [15:0]   dat_q, dat_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
`endif

  logic        tick, mid, last, push_req, push, pop, ferr_evt, perr_evt, ovr_evt;
  logic        empty, full, acc;
  logic [2:0]  clr;
  logic [15:0] status;
  logic        unused_wb;

  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    smp_d      = tick ? smp_q + 4'd1 : smp_q;
    mid        = tick && (smp_q == 4'd7);
    last       = tick && (smp_q == 4'd15);
    state_d    = state_q;
    bit_d      = bit_q;
    shr_d      = shr_q;
    push_req   = 1'b0;
    ferr_evt   = 1'b0;
    perr_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        smp_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (mid && rx_s2_q) state_d = S_IDLE;
        else if (last)      state_d = S_DATA;
      end
      S_DATA: begin
        if (mid) shr_d = {rx_s2_q, shr_q[7:1]};
        if (last) begin
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_bad_d = ^{rx_s2_q, shr_q};
          perr_evt  = ^{rx_s2_q, shr_q};
        end
        if (last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Return to IDLE at mid-stop so the next start edge is caught with half a bit to spare.
        if (mid) begin
`ifdef UART_RX_PARITY_EN
          push_req = rx_s2_q && !par_bad_q;
`else
          push_req = rx_s2_q;
`endif
          ferr_evt = !rx_s2_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    empty   = (wp_q == rp_q);
    full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    acc     = wb_cyc_i && wb_stb_i && !ack_q;
    pop     = acc && !wb_we_i && !wb_adr_i && !empty;
    push    = push_req && (!full || pop);
    ovr_evt = push_req && full && !pop;
    wp_d    = wp_q + {{AW{1'b0}}, push};
    rp_d    = rp_q + {{AW{1'b0}}, pop};
    avail_d = (wp_d != rp_d);
    ack_d   = acc;
    status  = {11'b0, perr_q, ovr_q, ferr_q, full, !empty};

    dat_d = dat_q;
    if (acc && !wb_we_i)
      dat_d = wb_adr_i ? status : {8'h00, empty ? 8'h00 : mem_q[rp_q[AW-1:0]]};

    clr    = (acc && wb_we_i && wb_adr_i) ? wb_dat_i[4:2] : 3'b000;
    ferr_d = (ferr_q && !clr[0]) || ferr_evt;
    ovr_d  = (ovr_q  && !clr[1]) || ovr_evt;
`ifdef UART_RX_PARITY_EN
    perr_d = (perr_q && !clr[2]) || perr_evt;
`else
    perr_d = 1'b0;
`endif
  end

  assign unused_wb = ^{wb_dat_i[15:5], wb_dat_i[1:0], clr[2], perr_evt};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      tick_cnt_q <= '0;
      smp_q      <= '0;
      state_q    <= S_IDLE;
      bit_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
      ack_q      <= 1'b0;
      avail_q    <= 1'b0;
      dat_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      tick_cnt_q <= tick_cnt_d;
      smp_q      <= smp_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
      ack_q      <= ack_d;
      avail_q    <= avail_d;
      dat_q      <= dat_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  // Datapath storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_in) begin
    shr_q <= shr_d;
    if (push) mem_q[wp_q[AW-1:0]] <= shr_q;
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign rx_avail = avail_q;
endmodule
